// File: rtl/freelist_checkpoint_ctrl.sv
// Branch checkpoint controller for the R10K free list: snapshots list/tail per branch,
// keeps live snapshots current with retired tags, and drives same-cycle mispredict recovery.
module freelist_checkpoint_ctrl #(
    parameter int unsigned NUM_CKPT     = 4,
    parameter int unsigned NUM_PHYS_REG = 64,
    parameter int unsigned PR_W         = $clog2(NUM_PHYS_REG) + 1,
    parameter int unsigned CNT_W        = $clog2(NUM_PHYS_REG) + 1,
    parameter int unsigned ID_W         = $clog2(NUM_CKPT)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 branch_dispatch,
    input  logic [NUM_PHYS_REG-1:0][PR_W-1:0]    free_list_in,
    input  logic [CNT_W-1:0]                     tail_in,
    input  logic                                 retire_en,
    input  logic [PR_W-1:0]                      T_old,
    input  logic                                 resolve_valid,
    input  logic [ID_W-1:0]                      resolve_id,
    input  logic                                 resolve_correct,
    output logic [ID_W-1:0]                      alloc_id,
    output logic                                 ckpt_full,
    output logic [ID_W:0]                        ckpt_count,
    output logic                                 branch_incorrect,
    output logic [NUM_PHYS_REG-1:0][PR_W-1:0]    free_check_point,
    output logic [CNT_W-1:0]                     tail_check_point,
    output logic [NUM_CKPT-1:0]                  squash_mask
);

    typedef logic [NUM_PHYS_REG-1:0][PR_W-1:0] list_t;

    localparam int unsigned       CntW    = ID_W + 1;
    localparam logic [CNT_W-1:0]  TailMax = CNT_W'(NUM_PHYS_REG);
    localparam logic [CNT_W-1:0]  TailOne = CNT_W'(1);

    logic [NUM_CKPT-1:0] valid_q, valid_d;
    list_t               list_q  [NUM_CKPT];
    list_t               list_d  [NUM_CKPT];
    logic [CNT_W-1:0]    tail_q  [NUM_CKPT];
    logic [CNT_W-1:0]    tail_d  [NUM_CKPT];
    logic [NUM_CKPT-1:0] older_q [NUM_CKPT];
    logic [NUM_CKPT-1:0] older_d [NUM_CKPT];

    logic                mispredict;
    logic                correct_hit;
    logic                allocate;
    logic [NUM_CKPT-1:0] clear_mask;

    // Write tag at position t; a saturated tail (t == NUM_PHYS_REG) matches no entry.
    function automatic list_t append(input list_t l, input logic [CNT_W-1:0] t,
                                     input logic [PR_W-1:0] tag);
        list_t r;
        r = l;
        for (int unsigned j = 0; j < NUM_PHYS_REG; j++) begin
            if (t == CNT_W'(j)) r[j] = tag;
        end
        return r;
    endfunction

    always_comb begin
        ckpt_count = '0;
        alloc_id   = '0;
        for (int i = NUM_CKPT - 1; i >= 0; i--) begin
            ckpt_count = ckpt_count + CntW'(valid_q[i]);
            if (!valid_q[i]) alloc_id = ID_W'(i);
        end
        ckpt_full = &valid_q;
    end

    assign mispredict  = resolve_valid && !resolve_correct && valid_q[resolve_id];
    assign correct_hit = resolve_valid && resolve_correct && valid_q[resolve_id];
    assign allocate    = branch_dispatch && !ckpt_full && !mispredict;

    always_comb begin
        branch_incorrect = mispredict;
        squash_mask      = '0;
        free_check_point = '0;
        tail_check_point = '0;
        if (mispredict) begin
            // Younger slots are exactly those that saw the resolving slot as older.
            for (int unsigned i = 0; i < NUM_CKPT; i++) begin
                if (ID_W'(i) == resolve_id || (valid_q[i] && older_q[i][resolve_id])) begin
                    squash_mask[i] = 1'b1;
                end
            end
            free_check_point = list_q[resolve_id];
            tail_check_point = tail_q[resolve_id];
            if (retire_en && tail_q[resolve_id] < TailMax) begin
                free_check_point = append(list_q[resolve_id], tail_q[resolve_id], T_old);
                tail_check_point = tail_q[resolve_id] + TailOne;
            end
        end
    end

    always_comb begin
        valid_d    = valid_q;
        list_d     = list_q;
        tail_d     = tail_q;
        older_d    = older_q;
        clear_mask = squash_mask;
        if (correct_hit) clear_mask[resolve_id] = 1'b1;

        for (int unsigned i = 0; i < NUM_CKPT; i++) begin
            if (retire_en && valid_q[i] && tail_q[i] < TailMax) begin
                list_d[i] = append(list_q[i], tail_q[i], T_old);
                tail_d[i] = tail_q[i] + TailOne;
            end
            older_d[i] = older_q[i] & ~clear_mask;
        end
        valid_d = valid_q & ~clear_mask;

        if (allocate) begin
            if (retire_en && tail_in < TailMax) begin
                list_d[alloc_id] = append(free_list_in, tail_in, T_old);
                tail_d[alloc_id] = tail_in + TailOne;
            end else begin
                list_d[alloc_id] = free_list_in;
                tail_d[alloc_id] = tail_in;
            end
            older_d[alloc_id] = valid_q & ~clear_mask;
            valid_d[alloc_id] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= '0;
            list_q  <= '{default: '0};
            tail_q  <= '{default: '0};
            older_q <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            list_q  <= list_d;
            tail_q  <= tail_d;
            older_q <= older_d;
        end
    end

endmodule

// File: tb/tb_freelist_checkpoint_ctrl.sv
// Self-checking bench for freelist_checkpoint_ctrl: directed scenarios plus randomized
// traffic checked against an age-ordered slot model.
module tb_freelist_checkpoint_ctrl;

    localparam int NC  = 4;
    localparam int NP  = 64;
    localparam int PRW = 7;
    localparam int CW  = 7;
    localparam int IW  = 2;

    typedef logic [NP-1:0][PRW-1:0] list_t;

    logic          clock;
    logic          reset;
    logic          bd;
    list_t         fl_in;
    logic [CW-1:0] tail_in;
    logic          ret;
    logic [PRW-1:0] told;
    logic          rv;
    logic [IW-1:0] rid;
    logic          rc;
    logic [IW-1:0] alloc_id;
    logic          ckpt_full;
    logic [IW:0]   ckpt_count;
    logic          branch_incorrect;
    list_t         fcp;
    logic [CW-1:0] tcp;
    logic [NC-1:0] squash_mask;

    int checks = 0;
    int errors = 0;

    freelist_checkpoint_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .branch_dispatch  (bd),
        .free_list_in     (fl_in),
        .tail_in          (tail_in),
        .retire_en        (ret),
        .T_old            (told),
        .resolve_valid    (rv),
        .resolve_id       (rid),
        .resolve_correct  (rc),
        .alloc_id         (alloc_id),
        .ckpt_full        (ckpt_full),
        .ckpt_count       (ckpt_count),
        .branch_incorrect (branch_incorrect),
        .free_check_point (fcp),
        .tail_check_point (tcp),
        .squash_mask      (squash_mask)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // Model: each live slot holds its list, tail and an allocation age; younger = larger age.
    bit    m_valid [NC];
    int    m_tail  [NC];
    list_t m_list  [NC];
    int    m_age   [NC];
    int    age_ctr = 0;

    task automatic model_step();
        int aid;
        bit mis, cor;
        bit kill [NC];
        if (reset) begin
            for (int s = 0; s < NC; s++) m_valid[s] = 0;
            return;
        end
        aid = -1;
        for (int s = NC - 1; s >= 0; s--) if (!m_valid[s]) aid = s;
        mis = rv && !rc && m_valid[rid];
        cor = rv && rc && m_valid[rid];
        for (int s = 0; s < NC; s++)
            kill[s] = mis && (s == int'(rid) || (m_valid[s] && m_age[s] > m_age[rid]));
        for (int s = 0; s < NC; s++) begin
            if (m_valid[s] && ret && m_tail[s] < NP) begin
                m_list[s][m_tail[s]] = told;
                m_tail[s]++;
            end
        end
        for (int s = 0; s < NC; s++) if (kill[s] || (cor && s == int'(rid))) m_valid[s] = 0;
        if (bd && aid >= 0 && !mis) begin
            m_list[aid] = fl_in;
            m_tail[aid] = int'(tail_in);
            if (ret && int'(tail_in) < NP) begin
                m_list[aid][tail_in] = told;
                m_tail[aid]++;
            end
            m_valid[aid] = 1;
            m_age[aid]   = age_ctr++;
        end
    endtask

    task automatic model_expect(output bit e_bi, output logic [NC-1:0] e_sq, output int e_tail,
                                output list_t e_list, output int e_aid, output bit e_full,
                                output int e_cnt);
        bit mis;
        e_cnt = 0;
        e_aid = 0;
        for (int s = NC - 1; s >= 0; s--) begin
            if (m_valid[s]) e_cnt++;
            else e_aid = s;
        end
        e_full = (e_cnt == NC);
        mis    = rv && !rc && m_valid[rid];
        e_bi   = mis;
        e_sq   = '0;
        e_tail = 0;
        e_list = '0;
        if (mis) begin
            for (int s = 0; s < NC; s++)
                if (s == int'(rid) || (m_valid[s] && m_age[s] > m_age[rid])) e_sq[s] = 1'b1;
            e_list = m_list[rid];
            e_tail = m_tail[rid];
            if (ret && e_tail < NP) begin
                e_list[e_tail] = told;
                e_tail++;
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bd   = 1'b0;
        ret  = 1'b0;
        told = '0;
        rv   = 1'b0;
        rid  = '0;
        rc   = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        bd      = 1'b1;
        tail_in = 7'd5;
        tick();
        tick();
        reset = 1'b0;
        idle();
        #1;
        checks++; if (ckpt_count !== 3'd0) begin errors++;
            $display("FAIL reset_count: got %0d expected 0", ckpt_count); end
        checks++; if (ckpt_full !== 1'b0) begin errors++;
            $display("FAIL reset_full: got %0b expected 0", ckpt_full); end
        checks++; if (alloc_id !== 2'd0) begin errors++;
            $display("FAIL reset_alloc_id: got %0d expected 0", alloc_id); end
        checks++; if (branch_incorrect !== 1'b0 || squash_mask !== 4'b0 || tcp !== 7'd0
                      || fcp !== '0) begin errors++;
            $display("FAIL reset_recovery: bi=%0b sq=%b tail=%0d expected all zero",
                     branch_incorrect, squash_mask, tcp); end
    endtask

    task automatic test_alloc_order();
        logic [IW-1:0] exp_id;
        do_reset();
        for (int i = 0; i < NC; i++) begin
            exp_id = IW'(i);
            checks++; if (alloc_id !== exp_id) begin errors++;
                $display("FAIL alloc_order_id: got %0d expected %0d", alloc_id, exp_id); end
            bd      = 1'b1;
            tail_in = CW'(32 - i);
            tick();
        end
        bd = 1'b0;
        checks++; if (ckpt_count !== 3'd4 || ckpt_full !== 1'b1) begin errors++;
            $display("FAIL alloc_full: count=%0d full=%0b expected 4/1", ckpt_count, ckpt_full); end
        bd      = 1'b1;
        tail_in = 7'd10;
        tick();
        bd = 1'b0;
        checks++; if (ckpt_count !== 3'd4) begin errors++;
            $display("FAIL alloc_fifth_dropped: count=%0d expected 4", ckpt_count); end
        rv = 1'b1; rc = 1'b0; rid = 2'd3;
        #1;
        checks++; if (branch_incorrect !== 1'b1 || tcp !== 7'd29 || squash_mask !== 4'b1000)
            begin errors++;
            $display("FAIL alloc_slot3_restore: bi=%0b tail=%0d sq=%b expected 1/29/1000",
                     branch_incorrect, tcp, squash_mask); end
        tick();
        idle();
        checks++; if (ckpt_count !== 3'd3 || alloc_id !== 2'd3) begin errors++;
            $display("FAIL alloc_after_squash: count=%0d id=%0d expected 3/3",
                     ckpt_count, alloc_id); end
    endtask

    task automatic test_correct_resolve();
        do_reset();
        tail_in = 7'd20;
        for (int i = 0; i < NC; i++) begin
            bd = 1'b1;
            tick();
        end
        // Freed slot must not be reusable in the cycle it is freed.
        rv = 1'b1; rc = 1'b1; rid = 2'd1; bd = 1'b1;
        #1;
        checks++; if (branch_incorrect !== 1'b0 || squash_mask !== 4'b0) begin errors++;
            $display("FAIL correct_no_strobe: bi=%0b sq=%b expected 0/0",
                     branch_incorrect, squash_mask); end
        tick();
        idle();
        checks++; if (alloc_id !== 2'd1 || ckpt_full !== 1'b0 || ckpt_count !== 3'd3) begin
            errors++;
            $display("FAIL correct_free: id=%0d full=%0b count=%0d expected 1/0/3",
                     alloc_id, ckpt_full, ckpt_count); end
    endtask

    task automatic test_retire_append();
        list_t exp_list;
        do_reset();
        fl_in    = '0;
        fl_in[0] = 7'd8;
        fl_in[1] = 7'd9;
        fl_in[2] = 7'd12;
        tail_in  = 7'd3;
        bd = 1'b1;
        tick();
        bd    = 1'b0;
        fl_in = '1;
        ret = 1'b1; told = 7'd5;
        tick();
        told = 7'd14;
        tick();
        ret = 1'b0;
        rv = 1'b1; rc = 1'b0; rid = 2'd0;
        #1;
        exp_list    = '0;
        exp_list[0] = 7'd8;
        exp_list[1] = 7'd9;
        exp_list[2] = 7'd12;
        exp_list[3] = 7'd5;
        exp_list[4] = 7'd14;
        checks++; if (branch_incorrect !== 1'b1 || tcp !== 7'd5) begin errors++;
            $display("FAIL retire_tail: bi=%0b tail=%0d expected 1/5", branch_incorrect, tcp); end
        checks++; if (fcp !== exp_list) begin errors++;
            $display("FAIL retire_list: got %h expected %h", fcp, exp_list); end
        tick();
        idle();
    endtask

    task automatic test_nested_squash();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            bd = 1'b1;
            tail_in = CW'(40 + i);
            tick();
        end
        bd = 1'b0;
        rv = 1'b1; rc = 1'b0; rid = 2'd1;
        #1;
        checks++; if (squash_mask !== 4'b0110 || branch_incorrect !== 1'b1) begin errors++;
            $display("FAIL nested_mask: sq=%b bi=%0b expected 0110/1",
                     squash_mask, branch_incorrect); end
        tick();
        idle();
        checks++; if (ckpt_count !== 3'd1 || alloc_id !== 2'd1 || ckpt_full !== 1'b0) begin
            errors++;
            $display("FAIL nested_after: count=%0d id=%0d full=%0b expected 1/1/0",
                     ckpt_count, alloc_id, ckpt_full); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        fl_in    = '0;
        fl_in[0] = 7'd21;
        fl_in[1] = 7'd22;
        tail_in  = 7'd2;
        bd = 1'b1;
        tick();
        rv = 1'b1; rc = 1'b0; rid = 2'd0; ret = 1'b1; told = 7'd7; tail_in = 7'd40;
        #1;
        checks++; if (tcp !== 7'd3 || fcp[2] !== 7'd7 || fcp[0] !== 7'd21
                      || branch_incorrect !== 1'b1) begin errors++;
            $display("FAIL simul_restore: tail=%0d list2=%0d list0=%0d bi=%0b expected 3/7/21/1",
                     tcp, fcp[2], fcp[0], branch_incorrect); end
        tick();
        idle();
        checks++; if (ckpt_count !== 3'd0 || alloc_id !== 2'd0) begin errors++;
            $display("FAIL simul_no_alloc: count=%0d id=%0d expected 0/0", ckpt_count, alloc_id); end
    endtask

    task automatic test_saturation_invalid();
        list_t sat_list;
        do_reset();
        fl_in     = '0;
        fl_in[63] = 7'd33;
        fl_in[5]  = 7'd17;
        sat_list  = fl_in;
        tail_in   = 7'd64;
        bd = 1'b1;
        tick();
        bd = 1'b0;
        ret = 1'b1; told = 7'd3;
        tick();
        ret = 1'b0;
        rv = 1'b1; rc = 1'b0; rid = 2'd2;
        #1;
        checks++; if (branch_incorrect !== 1'b0 || squash_mask !== 4'b0 || tcp !== 7'd0) begin
            errors++;
            $display("FAIL invalid_id: bi=%0b sq=%b tail=%0d expected 0/0/0",
                     branch_incorrect, squash_mask, tcp); end
        tick();
        checks++; if (ckpt_count !== 3'd1 || alloc_id !== 2'd1) begin errors++;
            $display("FAIL invalid_state: count=%0d id=%0d expected 1/1", ckpt_count, alloc_id); end
        rv = 1'b1; rc = 1'b0; rid = 2'd0; ret = 1'b1; told = 7'd9;
        #1;
        checks++; if (branch_incorrect !== 1'b1 || tcp !== 7'd64) begin errors++;
            $display("FAIL sat_tail: bi=%0b tail=%0d expected 1/64", branch_incorrect, tcp); end
        checks++; if (fcp !== sat_list) begin errors++;
            $display("FAIL sat_list: got %h expected %h", fcp, sat_list); end
        tick();
        idle();
    endtask

    task automatic test_random();
        bit              e_bi, e_full;
        logic [NC-1:0]   e_sq;
        int              e_tail, e_aid, e_cnt;
        list_t           e_list;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            reset = ($urandom_range(0, 199) == 0);
            bd    = 1'($urandom_range(0, 1));
            ret   = 1'($urandom_range(0, 1));
            told  = PRW'($urandom);
            rv    = ($urandom_range(0, 2) == 0);
            rid   = IW'($urandom);
            rc    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) tail_in = CW'($urandom_range(60, 64));
            else tail_in = CW'($urandom_range(0, 64));
            if (n % 8 == 0) for (int j = 0; j < NP; j++) fl_in[j] = PRW'($urandom);
            #1;
            if (!reset) begin
                model_expect(e_bi, e_sq, e_tail, e_list, e_aid, e_full, e_cnt);
                checks++; if (branch_incorrect !== e_bi) begin errors++;
                    $display("FAIL rand_bi[%0d]: got %0b expected %0b", n, branch_incorrect, e_bi); end
                checks++; if (squash_mask !== e_sq) begin errors++;
                    $display("FAIL rand_sq[%0d]: got %b expected %b", n, squash_mask, e_sq); end
                checks++; if (tcp !== CW'(e_tail)) begin errors++;
                    $display("FAIL rand_tail[%0d]: got %0d expected %0d", n, tcp, e_tail); end
                checks++; if (fcp !== e_list) begin errors++;
                    $display("FAIL rand_list[%0d]: got %h expected %h", n, fcp, e_list); end
                checks++; if (alloc_id !== IW'(e_aid)) begin errors++;
                    $display("FAIL rand_alloc[%0d]: got %0d expected %0d", n, alloc_id, e_aid); end
                checks++; if (ckpt_full !== e_full) begin errors++;
                    $display("FAIL rand_full[%0d]: got %0b expected %0b", n, ckpt_full, e_full); end
                checks++; if (ckpt_count !== 3'(e_cnt)) begin errors++;
                    $display("FAIL rand_count[%0d]: got %0d expected %0d", n, ckpt_count, e_cnt); end
            end
            tick();
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        reset   = 1'b1;
        fl_in   = '0;
        tail_in = '0;
        idle();
        #1;
        test_reset();
        test_alloc_order();
        test_correct_resolve();
        test_retire_append();
        test_nested_squash();
        test_simultaneous();
        test_saturation_invalid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
